piece_controller: RTL and testbench

- Holds the active tetromino: type, rotation, anchor column and anchor row.
- Turns spawn, move, rotate and gravity commands into four absolute cell coordinates.
- Drives them to the wall-kick/collision stage directly downstream and commits the stage's corrected columns as the new anchor.
- Detects the playfield floor (rows 0–21) and raises a one-cycle lock pulse when gravity cannot advance the piece.

---
 rtl/piece_controller.sv | 187 ++++++++++++++++++
 tb/tb_piece_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
// piece_controller: holds the active tetromino, turns commands into four
// proposed cell coordinates, and commits the downstream-corrected anchor.
module piece_controller #(
  parameter logic [3:0] SPAWN_X = 4'd4,
  parameter logic [4:0] SPAWN_Y = 5'd2,
  parameter logic [4:0] FLOOR_Y = 5'd21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn,
  input  logic [2:0] piece_type,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_rot,
  input  logic       tick_down,
  output logic [3:0] x1,
  output logic [3:0] x2,
  output logic [3:0] x3,
  output logic [3:0] x4,
  output logic [4:0] y1,
  output logic [4:0] y2,
  output logic [4:0] y3,
  output logic [4:0] y4,
  input  logic [3:0] xc1,
  input  logic [3:0] xc2,
  input  logic [3:0] xc3,
  input  logic [3:0] xc4,
  output logic       valid,
  output logic       busy,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PROPOSE} state_t;
  typedef enum logic [1:0] {K_SPAWN, K_MOVE, K_ROT, K_DOWN} kind_t;

  state_t     state_q, state_d;
  kind_t      p_kind_q, p_kind_d;
  logic [2:0] c_type_q, c_type_d;
  logic [1:0] c_rot_q, c_rot_d, p_rot_q, p_rot_d;
  logic [3:0] c_ax_q, c_ax_d, p_ax_q, p_ax_d;
  logic [4:0] c_ay_q, c_ay_d, p_ay_q, p_ay_d;
  logic       locked_q, locked_d;

  logic [3:0] cx [4];
  logic [4:0] cy [4];
  logic       floor_hit;
  logic [3:0] kick_d;

  // Downstream shifts all four columns equally, so xc1 alone carries the kick.
  logic unused_xc;
  assign unused_xc = ^{xc2, xc3, xc4};

  // Rotation-0 offsets packed as {dx0,dx1,dx2,dx3,dy0,dy1,dy2,dy3}, 3-bit two's complement.
  function automatic logic [23:0] base_offs(input logic [2:0] t);
    case (t)
      3'd1:    base_offs = {3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
      3'd2:    base_offs = {3'b111, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
      3'd3:    base_offs = {3'b000, 3'b001, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
      3'd4:    base_offs = {3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
      3'd5:    base_offs = {3'b111, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
      3'd6:    base_offs = {3'b111, 3'b000, 3'b001, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
      default: base_offs = {3'b111, 3'b000, 3'b001, 3'b010, 12'b0};
    endcase
  endfunction

  // Cell coordinates from the proposal anchor/rotation and the committed type.
  always_comb begin
    logic [23:0] tbl;
    logic [1:0]  eff_rot;
    logic [2:0]  bdx, bdy, rdx, rdy;
    tbl       = base_offs(c_type_q);
    eff_rot   = (c_type_q == 3'd1) ? 2'd0 : p_rot_q;
    floor_hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      bdx = tbl[23 - 3*i -: 3];
      bdy = tbl[11 - 3*i -: 3];
      case (eff_rot)
        2'd1:    begin rdx = -bdy; rdy = bdx;  end
        2'd2:    begin rdx = -bdx; rdy = -bdy; end
        2'd3:    begin rdx = bdy;  rdy = -bdx; end
        default: begin rdx = bdx;  rdy = bdy;  end
      endcase
      cx[i] = p_ax_q + {rdx[2], rdx};
      cy[i] = p_ay_q + {{2{rdy[2]}}, rdy};
      if (cy[i] > FLOOR_Y) floor_hit = 1'b1;
    end
  end

  assign x1 = cx[0];
  assign x2 = cx[1];
  assign x3 = cx[2];
  assign x4 = cx[3];
  assign y1 = cy[0];
  assign y2 = cy[1];
  assign y3 = cy[2];
  assign y4 = cy[3];
  assign kick_d = xc1 - cx[0];

  // Next-state: command acceptance, proposal resolution, commit/restore.
  always_comb begin
    state_d  = state_q;
    p_kind_d = p_kind_q;
    c_type_d = c_type_q;
    c_rot_d  = c_rot_q;
    c_ax_d   = c_ax_q;
    c_ay_d   = c_ay_q;
    p_rot_d  = p_rot_q;
    p_ax_d   = p_ax_q;
    p_ay_d   = p_ay_q;
    locked_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn && piece_type != 3'd7) begin
          c_type_d = piece_type;
          p_rot_d  = 2'd0;
          p_ax_d   = SPAWN_X;
          p_ay_d   = SPAWN_Y;
          p_kind_d = K_SPAWN;
          state_d  = PROPOSE;
        end
      end
      ACTIVE: begin
        if (tick_down) begin
          p_ay_d = p_ay_q + 5'd1; p_kind_d = K_DOWN; state_d = PROPOSE;
        end else if (cmd_rot) begin
          p_rot_d = p_rot_q + 2'd1; p_kind_d = K_ROT; state_d = PROPOSE;
        end else if (cmd_left) begin
          p_ax_d = p_ax_q - 4'd1; p_kind_d = K_MOVE; state_d = PROPOSE;
        end else if (cmd_right) begin
          p_ax_d = p_ax_q + 4'd1; p_kind_d = K_MOVE; state_d = PROPOSE;
        end
      end
      PROPOSE: begin
        if (floor_hit && (p_kind_q == K_DOWN || p_kind_q == K_ROT)) begin
          p_rot_d = c_rot_q;
          p_ax_d  = c_ax_q;
          p_ay_d  = c_ay_q;
          if (p_kind_q == K_DOWN) begin
            locked_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = ACTIVE;
          end
        end else begin
          c_ax_d  = p_ax_q + kick_d;
          p_ax_d  = p_ax_q + kick_d;
          c_rot_d = p_rot_q;
          c_ay_d  = p_ay_q;
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p_kind_q <= K_SPAWN;
      c_type_q <= '0;
      c_rot_q  <= '0;
      c_ax_q   <= SPAWN_X;
      c_ay_q   <= SPAWN_Y;
      p_rot_q  <= '0;
      p_ax_q   <= SPAWN_X;
      p_ay_q   <= SPAWN_Y;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_kind_q <= p_kind_d;
      c_type_q <= c_type_d;
      c_rot_q  <= c_rot_d;
      c_ax_q   <= c_ax_d;
      c_ay_q   <= c_ay_d;
      p_rot_q  <= p_rot_d;
      p_ax_q   <= p_ax_d;
      p_ay_q   <= p_ay_d;
      locked_q <= locked_d;
    end
  end

  assign valid  = (state_q != IDLE);
  assign busy   = (state_q == PROPOSE);
  assign locked = locked_q;

endmodule

// File: tb/tb_piece_controller.sv
// Scoreboard bench for piece_controller: a behavioural model predicts the
// outputs after every edge; the expected vectors are queued and popped.
module tb_piece_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spawn, cmd_left, cmd_right, cmd_rot, tick_down;
  logic [2:0] piece_type;
  logic [3:0] x1, x2, x3, x4, xc1, xc2, xc3, xc4;
  logic [4:0] y1, y2, y3, y4;
  logic       valid, busy, locked;
  logic [3:0] kick4;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [38:0] sb_q [$];

  always #5 clk = ~clk;

  // Downstream stand-in: shift all columns by the current kick amount.
  assign xc1 = x1 + kick4;
  assign xc2 = x2 + kick4;
  assign xc3 = x3 + kick4;
  assign xc4 = x4 + kick4;

  piece_controller #(.SPAWN_X(4'd4), .SPAWN_Y(5'd2), .FLOOR_Y(5'd21)) dut (
    .clk(clk), .rst_n(rst_n), .spawn(spawn), .piece_type(piece_type),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot),
    .tick_down(tick_down),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .xc1(xc1), .xc2(xc2), .xc3(xc3), .xc4(xc4),
    .valid(valid), .busy(busy), .locked(locked)
  );

  // Model state: 0 idle, 1 active, 2 propose; kind 0 spawn 1 move 2 rot 3 down
  int m_state, m_type, m_crot, m_cax, m_cay, m_prot, m_pax, m_pay, m_kind, m_locked;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int off(input int t, input int r, input int i, input bit want_y);
    int bx[4], by[4], tmp, rr;
    case (t)
      1: begin bx = '{0, 1, 0, 1};   by = '{0, 0, 1, 1}; end
      2: begin bx = '{-1, 0, 1, 0};  by = '{0, 0, 0, 1}; end
      3: begin bx = '{0, 1, -1, 0};  by = '{0, 0, 1, 1}; end
      4: begin bx = '{-1, 0, 0, 1};  by = '{0, 0, 1, 1}; end
      5: begin bx = '{-1, 0, 1, 1};  by = '{0, 0, 0, 1}; end
      6: begin bx = '{-1, 0, 1, -1}; by = '{0, 0, 0, 1}; end
      default: begin bx = '{-1, 0, 1, 2}; by = '{0, 0, 0, 0}; end
    endcase
    rr = (t == 1) ? 0 : r;
    for (int k = 0; k < rr; k++) begin
      tmp = bx[i]; bx[i] = -by[i]; by[i] = tmp;
    end
    return want_y ? by[i] : bx[i];
  endfunction

  function automatic int mx(input int i);
    return (m_pax + off(m_type, m_prot, i, 1'b0)) & 15;
  endfunction

  function automatic int my(input int i);
    return (m_pay + off(m_type, m_prot, i, 1'b1)) & 31;
  endfunction

  function automatic logic [38:0] model_vec();
    logic [38:0] v;
    v = {4'(mx(0)), 4'(mx(1)), 4'(mx(2)), 4'(mx(3)),
         5'(my(0)), 5'(my(1)), 5'(my(2)), 5'(my(3)),
         1'(m_state != 0), 1'(m_state == 2), 1'(m_locked)};
    return v;
  endfunction

  function automatic logic [38:0] dut_vec();
    return {x1, x2, x3, x4, y1, y2, y3, y4, valid, busy, locked};
  endfunction

  task automatic model_reset();
    m_state = 0; m_type = 0; m_crot = 0; m_prot = 0;
    m_cax = 4; m_pax = 4; m_cay = 2; m_pay = 2; m_kind = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit sp, input int pt, input bit l, input bit r,
                            input bit ro, input bit td, input int k);
    bit fl;
    int cur_x, d;
    m_locked = 0;
    case (m_state)
      0: if (sp && pt != 7) begin
           m_type = pt; m_prot = 0; m_pax = 4; m_pay = 2; m_kind = 0; m_state = 2;
         end
      1: begin
           if (td)      begin m_pay = (m_pay + 1) & 31;  m_kind = 3; m_state = 2; end
           else if (ro) begin m_prot = (m_prot + 1) & 3; m_kind = 2; m_state = 2; end
           else if (l)  begin m_pax = (m_pax - 1) & 15;  m_kind = 1; m_state = 2; end
           else if (r)  begin m_pax = (m_pax + 1) & 15;  m_kind = 1; m_state = 2; end
         end
      default: begin
        fl = 0;
        for (int i = 0; i < 4; i++) if (my(i) > 21) fl = 1;
        cur_x = mx(0);
        d = (((cur_x + k) & 15) - cur_x) & 15;
        if (fl && (m_kind == 3 || m_kind == 2)) begin
          m_prot = m_crot; m_pax = m_cax; m_pay = m_cay;
          if (m_kind == 3) begin m_locked = 1; m_state = 0; end
          else m_state = 1;
        end else begin
          m_cax = (m_pax + d) & 15; m_pax = m_cax;
          m_crot = m_prot; m_cay = m_pay; m_state = 1;
        end
      end
    endcase
  endtask

  // One clock cycle: drive inputs, queue the model's prediction, compare after the edge.
  task automatic step(input bit sp, input int pt, input bit l, input bit r,
                      input bit ro, input bit td, input int k);
    logic [38:0] exp;
    @(negedge clk);
    spawn = sp; piece_type = 3'(pt); cmd_left = l; cmd_right = r;
    cmd_rot = ro; tick_down = td; kick4 = 4'(k);
    model_step(sp, pt, l, r, ro, td, k);
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("cycle", 64'(dut_vec()), 64'(exp));
    spawn = 0; cmd_left = 0; cmd_right = 0; cmd_rot = 0; tick_down = 0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick(); step(0, 0, 0, 0, 0, 1, 0); idle(); endtask

  // Tick until the model reports the piece has locked (bounded).
  task automatic drop_until_lock();
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_state == 0) return;
    end
    check("lock_timeout", 64'(m_state), 64'(0));
  endtask

  localparam logic [38:0] RESET_VEC =
    {4'd3, 4'd4, 4'd5, 4'd6, 5'd2, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 0; spawn = 0; piece_type = 0; cmd_left = 0; cmd_right = 0;
    cmd_rot = 0; tick_down = 0; kick4 = 0;
    model_reset();
    #12;
    check("reset", 64'(dut_vec()), 64'(RESET_VEC));
    @(negedge clk); rst_n = 1;

    // Spawn T, then commit with unchanged columns.
    step(1, 2, 0, 0, 0, 0, 0);
    check("spawn_busy", 64'(busy), 64'(1));
    check("spawn_x1", 64'(x1), 64'(3));
    check("spawn_y4", 64'(y4), 64'(3));
    idle();
    check("spawn_valid", 64'({valid, busy}), 64'(2'b10));

    // Left-wall kick: walk T to ax=1, then left proposes x=15,0,1,0 and kick +1.
    repeat (3) begin step(0, 0, 1, 0, 0, 0, 0); idle(); end
    step(0, 0, 1, 0, 0, 0, 0);
    check("lkick_prop_x1", 64'(x1), 64'(15));
    step(0, 0, 0, 0, 0, 0, 1);
    check("lkick_commit_x1", 64'(x1), 64'(0));

    // Gravity lock of the T, with an I spawned in the lock cycle.
    drop_until_lock();
    check("lock_pulse", 64'({locked, valid}), 64'(2'b10));
    step(1, 0, 0, 0, 0, 0, 0);
    check("spawn_in_lock_cycle", 64'({locked, busy}), 64'(2'b01));
    idle();

    // Right-wall kick: I at ax=8, right proposes 8..11, downstream returns 7..10.
    repeat (4) begin step(0, 0, 0, 1, 0, 0, 0); idle(); end
    step(0, 0, 0, 1, 0, 0, 0);
    check("rkick_prop_x4", 64'(x4), 64'(11));
    step(0, 0, 0, 0, 0, 0, -1);
    check("rkick_commit_x4", 64'(x4), 64'(10));

    // Rotate reject at ay=20.
    repeat (18) tick();
    step(0, 0, 0, 0, 1, 0, 0);
    check("rot_prop_y4", 64'(y4), 64'(22));
    idle();
    check("rot_reject_y4", 64'(y4), 64'(20));

    // Fresh I, rotate accepted at ay=19.
    drop_until_lock();
    step(1, 0, 0, 0, 0, 0, 0); idle();
    repeat (17) tick();
    step(0, 0, 0, 0, 1, 0, 0); idle();
    check("rot_accept_y4", 64'(y4), 64'(21));

    // Simultaneous left+rot applies rotate only; left while busy ignored; spawn in ACTIVE ignored.
    step(0, 0, 1, 0, 1, 0, 0); idle();
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    idle();

    // Invalid type in IDLE.
    drop_until_lock();
    idle();
    step(1, 7, 0, 0, 0, 0, 0);
    check("type7_ignored", 64'({valid, busy}), 64'(0));

    // Reset during PROPOSE discards the proposal, no lock pulse.
    step(1, 6, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 0; model_reset();
    #1;
    check("reset_mid_propose", 64'(dut_vec()), 64'(RESET_VEC));
    @(negedge clk); rst_n = 1;
    idle();

    // Random command mix, including invalid types and kicks.
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 2)) - 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
